// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage register hazard scoreboard.
// Widths derive from the default parameterisation of hazard_scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_AW_DEF     = 5;
  localparam int unsigned MAX_LAT_DEF    = 8;
  localparam int unsigned FWD_STAGES_DEF = 2;
  localparam int unsigned LAT_W_DEF      = $clog2(MAX_LAT_DEF + 1);
  localparam int unsigned SEL_W_DEF      = $clog2(FWD_STAGES_DEF + 1);

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;
  typedef logic [LAT_W_DEF-1:0]  lat_t;
  typedef logic [SEL_W_DEF-1:0]  fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_REGFILE = fwd_sel_t'(0);
  localparam lat_t     LAT_ALU         = lat_t'(1);
  localparam lat_t     LAT_LOAD        = lat_t'(2);
  localparam lat_t     LAT_MUL         = lat_t'(4);

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's scoreboard slot: countdown to bypass tap 1, then a
// saturating age that walks the value down the bypass taps into the regfile.
module scoreboard_entry #(
  parameter int unsigned LAT_W      = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned FWD_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [LAT_W-1:0] wr_lat,
  output logic [LAT_W-1:0] cnt,
  output logic [SEL_W-1:0] age
);

  localparam logic [SEL_W-1:0] AGE_MAX = SEL_W'(FWD_STAGES);

  // A new issue overrides any countdown already running on this register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      age <= AGE_MAX;
    end else if (wr_en) begin
      cnt <= wr_lat;
      age <= '0;
    end else if (cnt > LAT_W'(1)) begin
      cnt <= cnt - LAT_W'(1);
    end else if (cnt == LAT_W'(1)) begin
      cnt <= '0;
      age <= '0;
    end else if (age < AGE_MAX) begin
      age <= age + SEL_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stall/issue decision and per-operand bypass selects.
// Optional perf counters enabled by defining HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned MAX_LAT    = MAX_LAT_DEF,
  parameter int unsigned FWD_STAGES = FWD_STAGES_DEF,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [REG_AW-1:0]                 id_rs,
  input  logic [REG_AW-1:0]                 id_rt,
  input  logic                              id_rs_used,
  input  logic                              id_rt_used,
  input  logic                              id_we,
  input  logic [REG_AW-1:0]                 id_dst,
  input  logic [$clog2(MAX_LAT+1)-1:0]      id_lat,
  input  logic                              flush,
  output logic                              stall,
  output logic                              issue,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_rt_sel
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                       perf_stall_cnt,
  output logic [31:0]                       perf_issue_cnt
`endif
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1);
  localparam int unsigned SEL_W    = $clog2(FWD_STAGES + 1);
  localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);
  localparam logic [SEL_W-1:0] AGE_MAX   = SEL_W'(FWD_STAGES);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [SEL_W-1:0] age [NUM_REGS];
  logic [LAT_W-1:0] lat_eff;
  logic             rs_busy;
  logic             rt_busy;
  logic             waw;

  // Zero latency is promoted to one; oversized latencies clamp to MAX_LAT.
  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0)            lat_eff = LAT_W'(1);
    else if (id_lat > LAT_MAX_V) lat_eff = LAT_MAX_V;
  end

  function automatic logic [SEL_W-1:0] bypass_sel(input logic used,
                                                  input logic [REG_AW-1:0] addr,
                                                  input logic [SEL_W-1:0] a);
    if (!used || (ZERO_REG != 0 && addr == '0) || a >= AGE_MAX) return FWD_SEL_REGFILE;
    return a + SEL_W'(1);
  endfunction

  // Hazard decision reads pre-issue state, so a self read/write sees the old entry.
  always_comb begin
    rs_busy    = id_rs_used && (cnt[id_rs] != '0);
    rt_busy    = id_rt_used && (cnt[id_rt] != '0);
    waw        = id_we && (cnt[id_dst] > lat_eff);
    stall      = rst && id_valid && !flush && (rs_busy || rt_busy || waw);
    issue      = rst && id_valid && !flush && !(rs_busy || rt_busy || waw);
    fwd_rs_sel = bypass_sel(id_rs_used, id_rs, age[id_rs]);
    fwd_rt_sel = bypass_sel(id_rt_used, id_rt, age[id_rt]);
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    localparam bit IS_ZERO = (ZERO_REG != 0) && (r == 0);
    logic wr_en;
    assign wr_en = !IS_ZERO && issue && id_we && (id_dst == REG_AW'(r));

    scoreboard_entry #(
      .LAT_W      (LAT_W),
      .SEL_W      (SEL_W),
      .FWD_STAGES (FWD_STAGES)
    ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .wr_lat (lat_eff),
      .cnt    (cnt[r]),
      .age    (age[r])
    );
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// checked against a completion-timestamp model of every register.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int FWD = 2;
  localparam int MAXL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic       id_we = 1'b0;
  logic [4:0] id_dst = '0;
  logic [3:0] id_lat = 4'd1;
  logic       flush = 1'b0;
  logic       stall;
  logic       issue;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_we      (id_we),
    .id_dst     (id_dst),
    .id_lat     (id_lat),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: cycle at which each register's result first sits on bypass tap 1.
  int now = 0;
  int done_cyc [32];

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, now);
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) done_cyc[r] = -1000;
    now = 0;
  endfunction

  function automatic int lat_of(input int l);
    if (l == 0) return 1;
    if (l > MAXL) return MAXL;
    return l;
  endfunction

  function automatic int m_cnt(input int r);
    return (done_cyc[r] > now) ? done_cyc[r] - now : 0;
  endfunction

  function automatic int m_age(input int r);
    if (done_cyc[r] > now) return 0;
    return (now - done_cyc[r] >= FWD) ? FWD : now - done_cyc[r];
  endfunction

  function automatic int m_sel(input bit used, input int r);
    if (!used || r == 0) return 0;
    return (m_age(r) < FWD) ? m_age(r) + 1 : 0;
  endfunction

  // Check combinational outputs mid-cycle, then advance the model across the edge.
  task automatic cycle_check(input string tag);
    bit hz, e_stall, e_issue;
    int l;
    @(negedge clk);
    l  = lat_of(int'(id_lat));
    hz = (id_rs_used && m_cnt(int'(id_rs)) != 0) ||
         (id_rt_used && m_cnt(int'(id_rt)) != 0) ||
         (id_we && m_cnt(int'(id_dst)) > l);
    e_stall = id_valid && !flush && hz;
    e_issue = id_valid && !flush && !hz;
    check({tag, ".stall"}, int'(stall), int'(e_stall));
    check({tag, ".issue"}, int'(issue), int'(e_issue));
    check({tag, ".rs_sel"}, int'(fwd_rs_sel), m_sel(id_rs_used, int'(id_rs)));
    check({tag, ".rt_sel"}, int'(fwd_rt_sel), m_sel(id_rt_used, int'(id_rt)));
    @(posedge clk);
    now++;
    if (e_issue && id_we && id_dst != 5'd0) done_cyc[id_dst] = now + l;
    #1;
  endtask

  task automatic instr(input string tag, input int rs, input bit rsu, input int rt,
                       input bit rtu, input bit we, input int dst, input int lat,
                       input bit fl);
    id_valid = 1'b1;
    id_rs = 5'(rs); id_rs_used = rsu;
    id_rt = 5'(rt); id_rt_used = rtu;
    id_we = we; id_dst = 5'(dst); id_lat = 4'(lat);
    flush = fl;
    cycle_check(tag);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".stall"}, int'(stall), 0);
    check({tag, ".issue"}, int'(issue), 0);
    check({tag, ".rs_sel"}, int'(fwd_rs_sel), 0);
    check({tag, ".rt_sel"}, int'(fwd_rt_sel), 0);
  endtask

  task automatic rand_inputs();
    id_valid   = ($urandom_range(0, 9) != 0);
    id_rs      = 5'($urandom_range(0, 7));
    id_rt      = 5'($urandom_range(0, 7));
    id_rs_used = 1'($urandom);
    id_rt_used = 1'($urandom);
    id_we      = 1'($urandom);
    id_dst     = 5'($urandom_range(0, 7));
    id_lat     = 4'($urandom_range(0, 15));
    flush      = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    model_reset();
    id_valid = 1'b1; id_rs = 5'd5; id_rs_used = 1'b1; id_we = 1'b1; id_dst = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset_checks("reset");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    instr("rd_r5", 5, 1, 0, 0, 0, 0, 1, 0);
    instr("alu_r3", 1, 1, 2, 1, 1, 3, int'(LAT_ALU), 0);
    for (int i = 0; i < 4; i++) instr("alu_use", 3, 1, 0, 0, 0, 0, 1, 0);
    instr("lw_r4", 1, 1, 0, 0, 1, 4, int'(LAT_LOAD), 0);
    for (int i = 0; i < 4; i++) instr("load_use", 0, 0, 4, 1, 1, 9, 1, 0);
    instr("mul_r6", 1, 1, 2, 1, 1, 6, int'(LAT_MUL), 0);
    for (int i = 0; i < 4; i++) instr("waw", 1, 1, 0, 0, 1, 6, int'(LAT_ALU), 0);
    for (int i = 0; i < 3; i++) instr("waw_rd", 6, 1, 6, 1, 0, 0, 1, 0);
    instr("lw_r7", 1, 1, 0, 0, 1, 7, int'(LAT_LOAD), 0);
    instr("flush", 7, 1, 0, 0, 1, 8, 5, 1);
    instr("post_flush", 8, 1, 0, 0, 0, 0, 1, 0);
    instr("wr_r0", 0, 0, 0, 0, 1, 0, 3, 0);
    instr("rd_r0", 0, 1, 0, 1, 0, 0, 1, 0);
    instr("lat0", 0, 0, 0, 0, 1, 10, 0, 0);
    instr("lat0_use", 10, 1, 0, 0, 0, 0, 1, 0);
    instr("lat15", 0, 0, 0, 0, 1, 11, 15, 0);
    for (int i = 0; i < 10; i++) instr("lat15_use", 0, 0, 11, 1, 1, 11, 15, 0);

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle_check("rand");
    end

    // Asynchronous reset mid-operation with traffic still pending.
    instr("pre_rst", 0, 0, 0, 0, 1, 2, 8, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    id_valid = 1'b1; id_rs = 5'd2; id_rs_used = 1'b1; flush = 1'b0;
    #1;
    reset_checks("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    instr("after_rst", 2, 1, 2, 1, 1, 2, 1, 0);

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cycle_check("rand2");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
